// File: rtl/uart_hex_display.sv
`default_nettype none
// ============================================================================
// Module   : uart_hex_display
// Brief    : Parses STX/hex/ETX framed packets from a UART RX byte stream into
//            an N-digit hex display register and scans it onto a
//            common-anode 7-segment display (active-low anodes and segments).
// Revision : 1.0  initial release
// ============================================================================
module uart_hex_display #(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_CLKS = 7000
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Rx_DV,
    input  logic [7:0]            i_Rx_Byte,
    output logic                  o_Frame_Ok,
    output logic                  o_Frame_Err,
    output logic [4*N_DIGITS-1:0] o_Display_Value,
    output logic [N_DIGITS-1:0]   o_Anode,
    output logic [6:0]            o_Segment
);

    localparam int DW    = 4 * N_DIGITS;
    localparam int SCN_W = $clog2(SCAN_CLKS);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [7:0]       c_STX      = 8'h02;
    localparam logic [7:0]       c_ETX      = 8'h03;
    localparam logic [3:0]       c_LAST_CHR = 4'(N_DIGITS - 1);
    localparam logic [SCN_W-1:0] c_SCAN_TC  = SCN_W'(SCAN_CLKS - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(N_DIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_ETX  = 2'd2;

    logic [1:0]       r_state,   w_state_nxt;
    logic [DW-1:0]    r_shadow,  w_shadow_nxt;
    logic [3:0]       r_count,   w_count_nxt;
    logic [DW-1:0]    r_display, w_display_nxt;
    logic             r_ok,      w_ok_nxt;
    logic             r_err,     w_err_nxt;
    logic [DW+3:0]    w_shift_full;
    logic             w_is_hex;
    logic [3:0]       w_nibble;

    logic [SCN_W-1:0] r_scan_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [N_DIGITS-1:0] r_anode;
    logic [6:0]       r_segment;
    logic [3:0]       w_scan_nibble;
    logic [6:0]       w_font;

    // ASCII hex character decode
    always_comb begin
        w_is_hex = 1'b1;
        w_nibble = 4'h0;
        if (i_Rx_Byte >= 8'h30 && i_Rx_Byte <= 8'h39)
            w_nibble = i_Rx_Byte[3:0];
        else if ((i_Rx_Byte >= 8'h41 && i_Rx_Byte <= 8'h46) ||
                 (i_Rx_Byte >= 8'h61 && i_Rx_Byte <= 8'h66))
            w_nibble = i_Rx_Byte[3:0] + 4'd9;
        else
            w_is_hex = 1'b0;
    end

    // New char enters at the right; earlier chars move toward the left digit
    assign w_shift_full = {r_shadow, w_nibble};

    // Parser state register and registered outputs
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state   <= S_IDLE;
            r_shadow  <= '0;
            r_count   <= 4'd0;
            r_display <= '0;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shadow  <= w_shadow_nxt;
            r_count   <= w_count_nxt;
            r_display <= w_display_nxt;
            r_ok      <= w_ok_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Parser next-state: only bytes qualified by DV are looked at
    always_comb begin
        w_state_nxt   = r_state;
        w_shadow_nxt  = r_shadow;
        w_count_nxt   = r_count;
        w_display_nxt = r_display;
        w_ok_nxt      = 1'b0;
        w_err_nxt     = 1'b0;
        if (i_Rx_DV) begin
            case (r_state)
                S_IDLE: begin
                    if (i_Rx_Byte == c_STX) begin
                        w_shadow_nxt = '0;
                        w_count_nxt  = 4'd0;
                        w_state_nxt  = S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_is_hex) begin
                        w_shadow_nxt = w_shift_full[DW-1:0];
                        w_count_nxt  = r_count + 4'd1;
                        if (r_count == c_LAST_CHR)
                            w_state_nxt = S_ETX;
                    end else if (i_Rx_Byte == c_STX) begin
                        w_shadow_nxt = '0;
                        w_count_nxt  = 4'd0;
                        w_err_nxt    = 1'b1;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_ETX: begin
                    if (i_Rx_Byte == c_ETX) begin
                        w_display_nxt = r_shadow;
                        w_ok_nxt      = 1'b1;
                        w_state_nxt   = S_IDLE;
                    end else if (i_Rx_Byte == c_STX) begin
                        w_shadow_nxt = '0;
                        w_count_nxt  = 4'd0;
                        w_err_nxt    = 1'b1;
                        w_state_nxt  = S_DATA;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Scan timer and digit index, free-running and independent of the parser
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (r_scan_cnt == c_SCAN_TC) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign w_scan_nibble = r_display[{r_idx, 2'b00} +: 4];

    // Hex glyph lookup, active-low {g,f,e,d,c,b,a}
    always_comb begin
        w_font = 7'b1000000;
        case (w_scan_nibble)
            4'h0: w_font = 7'b1000000;
            4'h1: w_font = 7'b1111001;
            4'h2: w_font = 7'b0100100;
            4'h3: w_font = 7'b0110000;
            4'h4: w_font = 7'b0011001;
            4'h5: w_font = 7'b0010010;
            4'h6: w_font = 7'b0000010;
            4'h7: w_font = 7'b1111000;
            4'h8: w_font = 7'b0000000;
            4'h9: w_font = 7'b0010000;
            4'hA: w_font = 7'b0001000;
            4'hB: w_font = 7'b0000011;
            4'hC: w_font = 7'b1000110;
            4'hD: w_font = 7'b0100001;
            4'hE: w_font = 7'b0000110;
            4'hF: w_font = 7'b0001110;
            default: w_font = 7'b1000000;
        endcase
    end

    // Anode and segment registered together from the same index
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_anode   <= ~N_DIGITS'(1);
            r_segment <= 7'b1000000;
        end else begin
            r_anode   <= ~(N_DIGITS'(1) << r_idx);
            r_segment <= w_font;
        end
    end

    assign o_Frame_Ok      = r_ok;
    assign o_Frame_Err     = r_err;
    assign o_Display_Value = r_display;
    assign o_Anode         = r_anode;
    assign o_Segment       = r_segment;

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_hex_display
// Brief    : Directed self-checking bench for uart_hex_display (4 digits,
//            4-clock scan period).
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_hex_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        ok, err;
    logic [15:0] disp;
    logic [3:0]  anode;
    logic [6:0]  seg;

    int total = 0;
    int bad   = 0;

    uart_hex_display #(.N_DIGITS(4), .SCAN_CLKS(4)) dut (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_Rx_DV        (rx_dv),
        .i_Rx_Byte      (rx_byte),
        .o_Frame_Ok     (ok),
        .o_Frame_Err    (err),
        .o_Display_Value(disp),
        .o_Anode        (anode),
        .o_Segment      (seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present one byte; with gap=1 DV drops for a cycle and both pulses must be gone
    task automatic send(input logic [7:0] b, input logic eo, input logic ee, input bit gap);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk); #1;
        chk($sformatf("ok@%h", b), {31'd0, ok}, {31'd0, eo});
        chk($sformatf("err@%h", b), {31'd0, err}, {31'd0, ee});
        if (gap) begin
            @(negedge clk);
            rx_dv = 1'b0;
            @(posedge clk); #1;
            chk("ok_gone", {31'd0, ok}, 32'd0);
            chk("err_gone", {31'd0, err}, 32'd0);
        end
    endtask

    task automatic dv_off();
        @(negedge clk);
        rx_dv = 1'b0;
        @(posedge clk); #1;
        chk("ok_after_burst", {31'd0, ok}, 32'd0);
        chk("err_after_burst", {31'd0, err}, 32'd0);
    endtask

    // Wait (bounded) for a digit to be lit and check its glyph
    task automatic chk_digit(input logic [3:0] an, input logic [6:0] exp_seg, input string tag);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            if (anode == an) found = 1;
        end
        chk({tag, "_lit"}, {31'd0, found}, 32'd1);
        if (found) chk(tag, {25'd0, seg}, {25'd0, exp_seg});
    endtask

    initial begin
        logic [3:0] prev;
        logic [3:0] seq [4];
        bit         found;

        // 1: reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_disp", {16'd0, disp}, 32'h0);
        chk("rst_anode", {28'd0, anode}, 32'he);
        chk("rst_seg", {25'd0, seg}, 32'h40);
        chk("rst_ok", {31'd0, ok}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_anode", {28'd0, anode}, 32'he);
        chk("post_rst_disp", {16'd0, disp}, 32'h0);

        // 2: good frame, mixed case
        send(8'h02, 0, 0, 1);
        send(8'h31, 0, 0, 1);
        send(8'h32, 0, 0, 1);
        send(8'h61, 0, 0, 1);
        send(8'h46, 0, 0, 0);
        chk("disp_before_etx", {16'd0, disp}, 32'h0);
        send(8'h03, 1, 0, 1);
        chk("disp_12AF", {16'd0, disp}, 32'h12AF);
        chk_digit(4'b1110, 7'b0001110, "seg_d0_F");
        chk_digit(4'b1101, 7'b0001000, "seg_d1_A");
        chk_digit(4'b0111, 7'b1111001, "seg_d3_1");

        // 3: invalid char aborts; trailing bytes ignored until STX
        send(8'h02, 0, 0, 1);
        send(8'h31, 0, 0, 1);
        send(8'h47, 0, 1, 1);
        send(8'h35, 0, 0, 1);
        send(8'h36, 0, 0, 1);
        send(8'h03, 0, 0, 1);
        chk("disp_after_bad_char", {16'd0, disp}, 32'h12AF);

        // 4: short frame, then long frame
        send(8'h02, 0, 0, 1);
        send(8'h31, 0, 0, 1);
        send(8'h32, 0, 0, 1);
        send(8'h33, 0, 0, 1);
        send(8'h03, 0, 1, 1);
        chk("disp_after_short", {16'd0, disp}, 32'h12AF);
        send(8'h02, 0, 0, 1);
        send(8'h31, 0, 0, 1);
        send(8'h32, 0, 0, 1);
        send(8'h33, 0, 0, 1);
        send(8'h34, 0, 0, 1);
        send(8'h35, 0, 1, 1);
        send(8'h03, 0, 0, 1);
        chk("disp_after_long", {16'd0, disp}, 32'h12AF);

        // 5a: restart mid-frame, gapped DV
        send(8'h02, 0, 0, 1);
        send(8'h31, 0, 0, 1);
        send(8'h32, 0, 0, 1);
        send(8'h02, 0, 1, 1);
        send(8'h35, 0, 0, 1);
        send(8'h36, 0, 0, 1);
        send(8'h37, 0, 0, 1);
        send(8'h38, 0, 0, 1);
        send(8'h03, 1, 0, 1);
        chk("disp_5678", {16'd0, disp}, 32'h5678);

        // 5b: restart mid-frame, DV on consecutive cycles
        send(8'h02, 0, 0, 0);
        send(8'h31, 0, 0, 0);
        send(8'h32, 0, 0, 0);
        send(8'h02, 0, 1, 0);
        send(8'h39, 0, 0, 0);
        send(8'h61, 0, 0, 0);
        send(8'h42, 0, 0, 0);
        send(8'h63, 0, 0, 0);
        send(8'h03, 1, 0, 0);
        dv_off();
        chk("disp_9ABC_b2b", {16'd0, disp}, 32'h9ABC);

        // 5c: STX in the ETX slot restarts with an error
        send(8'h02, 0, 0, 1);
        send(8'h34, 0, 0, 1);
        send(8'h34, 0, 0, 1);
        send(8'h34, 0, 0, 1);
        send(8'h34, 0, 0, 1);
        send(8'h02, 0, 1, 1);
        send(8'h65, 0, 0, 1);
        send(8'h44, 0, 0, 1);
        send(8'h30, 0, 0, 1);
        send(8'h38, 0, 0, 1);
        send(8'h03, 1, 0, 1);
        chk("disp_ED08", {16'd0, disp}, 32'hED08);

        // 5d: asynchronous reset mid-frame discards it
        send(8'h02, 0, 0, 1);
        send(8'h31, 0, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_disp", {16'd0, disp}, 32'h0);
        chk("async_rst_anode", {28'd0, anode}, 32'he);
        chk("async_rst_seg", {25'd0, seg}, 32'h40);
        @(negedge clk);
        rst = 1'b0;
        send(8'h32, 0, 0, 1);
        send(8'h33, 0, 0, 1);
        send(8'h34, 0, 0, 1);
        send(8'h35, 0, 0, 1);
        send(8'h03, 0, 0, 1);
        chk("disp_after_rst_frame", {16'd0, disp}, 32'h0);

        // 6: scan order and period
        seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;
        found = 0;
        prev  = anode;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            if (anode == 4'b1110 && prev != 4'b1110) found = 1;
            prev = anode;
        end
        chk("scan_sync", {31'd0, found}, 32'd1);
        if (found) begin
            for (int k = 0; k < 4; k++) begin
                repeat (3) @(posedge clk);
                #1;
                chk($sformatf("scan_hold%0d", k), {28'd0, anode}, {28'd0, (k == 0) ? 4'b1110 : seq[k-1]});
                @(posedge clk); #1;
                chk($sformatf("scan_step%0d", k), {28'd0, anode}, {28'd0, seq[k]});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
